// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
//  - WB_SEL_*  : RegisterFileWriteSelect encodings seen on ex_wb_sel
//  - FWD_*     : EX operand source select driven on fwd_a / fwd_b
//  - state_e   : sequencer states (RUN / MEM_WAIT)
//  - strobe_t  : bundle of per-stage stall/flush strobes
package pipeline_hazard_ctrl_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_DRAM = 2'b01;
   localparam logic [1:0] WB_SEL_PC   = 2'b10;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_stall;
      logic idex_flush;
      logic exmem_stall;
      logic memwb_bubble;
   } strobe_t;

   // EX operands that get a forwarding compare (rs1 -> fwd_a, rs2 -> fwd_b).
   localparam int NUM_OPS = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//  master : the pipeline datapath (drives stage register fields, consumes strobes)
//  slave  : pipeline_hazard_ctrl
// Inputs to the controller: id_*, ex_*, mem_*, wb_* stage fields.
// Outputs from the controller: stall/flush strobes, fwd_a/fwd_b,
// stall_cycles, mem_timeout.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] id_rs1, id_rs2;
   logic              id_rs1_used, id_rs2_used;
   logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic              ex_we;
   logic [1:0]        ex_wb_sel;
   logic              ex_branch_taken;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_we, mem_req, mem_ready;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_we;

   logic              pc_stall, ifid_stall, ifid_flush;
   logic              idex_stall, idex_flush, exmem_stall, memwb_bubble;
   logic [1:0]        fwd_a, fwd_b;
   logic [CNT_W-1:0]  stall_cycles;
   logic              mem_timeout;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             ex_rs1, ex_rs2, ex_rd, ex_we, ex_wb_sel, ex_branch_taken,
             mem_rd, mem_we, mem_req, mem_ready, wb_rd, wb_we,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, memwb_bubble, fwd_a, fwd_b, stall_cycles, mem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             ex_rs1, ex_rs2, ex_rd, ex_we, ex_wb_sel, ex_branch_taken,
             mem_rd, mem_we, mem_req, mem_ready, wb_rd, wb_we,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, memwb_bubble, fwd_a, fwd_b, stall_cycles, mem_timeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational forwarding compare for one EX operand.
//  src            in   REG_AW  EX-stage source register
//  mem_rd/mem_we  in           EX/MEM destination and write enable
//  wb_rd/wb_we    in           MEM/WB destination and write enable
//  sel            out  2       FWD_MEM, FWD_WB or FWD_REG
// MEM wins over WB because it holds the younger write to the same register.
// x0 is hardwired zero, so it is never forwarded.
module fwd_unit
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_REG;
      if (mem_we && (mem_rd != '0) && (mem_rd == src))
         sel = FWD_MEM;
      else if (wb_we && (wb_rd != '0) && (wb_rd == src))
         sel = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central sequencer for the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers.
//  clk, rst  : rising-edge clock, asynchronous active-high reset
//  hz        : slave side of pipeline_hazard_ctrl_if
//              in : ID/EX/MEM/WB register fields, branch outcome, DRAM handshake
//              out: stall/flush strobes, fwd_a/fwd_b, stall_cycles, mem_timeout
// Strobes and forwarding selects are combinational so they take effect at the
// coming edge. A DRAM wait freezes the whole front of the pipe and bubbles
// MEM/WB; otherwise a taken branch flushes, otherwise a load-use inserts one
// bubble. MEM_TIMEOUT must be at least 1.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int         REG_AW      = 5,
   parameter logic [1:0] WB_SEL_DRAM = pipeline_hazard_ctrl_pkg::WB_SEL_DRAM,
   parameter int         MEM_TIMEOUT = 15,
   parameter int         CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int              WW  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0]   TMO = WW'(MEM_TIMEOUT);

   state_e           state, state_nxt;
   logic [WW-1:0]    wait_cnt;
   logic [CNT_W-1:0] stall_cycles;
   logic             mem_timeout;
   logic             load_use, mem_busy;
   strobe_t          strb;

   // ---------------- forwarding, one compare per EX operand ----------------
   logic [NUM_OPS-1:0][REG_AW-1:0] op_src;
   logic [NUM_OPS-1:0][1:0]        op_sel;

   assign op_src = {hz.ex_rs2, hz.ex_rs1};

   for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
      fwd_unit #(.REG_AW(REG_AW)) u_fwd (
         .src    (op_src[i]),
         .mem_rd (hz.mem_rd),
         .mem_we (hz.mem_we),
         .wb_rd  (hz.wb_rd),
         .wb_we  (hz.wb_we),
         .sel    (op_sel[i])
      );
   end

   // ---------------- hazard detect, strobe priority, next state ----------------
   always_comb begin
      load_use = hz.ex_we && (hz.ex_wb_sel == WB_SEL_DRAM) && (hz.ex_rd != '0) &&
                 ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                  (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
      mem_busy = hz.mem_req && !hz.mem_ready;

      strb      = '0;
      state_nxt = state;

      if (mem_busy) begin
         // EX is frozen too, so any branch/load-use is seen again after the wait.
         strb.pc_stall     = 1'b1;
         strb.ifid_stall   = 1'b1;
         strb.idex_stall   = 1'b1;
         strb.exmem_stall  = 1'b1;
         strb.memwb_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
         // The ID instruction is wrong-path, so its load-use is irrelevant.
         strb.ifid_flush = 1'b1;
         strb.idex_flush = 1'b1;
      end else if (load_use) begin
         // Next cycle the load has left EX, so the bubble lasts one cycle.
         strb.pc_stall   = 1'b1;
         strb.ifid_stall = 1'b1;
         strb.idex_flush = 1'b1;
      end

      unique case (state)
         ST_RUN:      if (mem_busy) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (hz.mem_req && hz.mem_ready) state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase

      if (rst) strb = '0;
   end

   // ---------------- state, wait counter, statistics ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RUN;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt == ST_RUN)
            wait_cnt <= '0;
         else if ((state == ST_MEM_WAIT) && (wait_cnt != TMO))
            wait_cnt <= wait_cnt + WW'(1);

         // Sticky: the FSM keeps waiting, software reads the flag.
         if (wait_cnt == TMO)
            mem_timeout <= 1'b1;

         if (strb.pc_stall)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   // ---------------- outputs ----------------
   assign hz.pc_stall     = strb.pc_stall;
   assign hz.ifid_stall   = strb.ifid_stall;
   assign hz.ifid_flush   = strb.ifid_flush;
   assign hz.idex_stall   = strb.idex_stall;
   assign hz.idex_flush   = strb.idex_flush;
   assign hz.exmem_stall  = strb.exmem_stall;
   assign hz.memwb_bubble = strb.memwb_bubble;
   assign hz.fwd_a        = rst ? 2'b00 : op_sel[0];
   assign hz.fwd_b        = rst ? 2'b00 : op_sel[1];
   assign hz.stall_cycles = stall_cycles;
   assign hz.mem_timeout  = mem_timeout;

endmodule
